if_queue: RTL and testbench

IF_QUEUE -- requirements
Module: if_queue

---
 rtl/lc3b_types.sv | 12 +
 rtl/if_queue_ptr.sv | 35 +++
 rtl/if_queue.sv | 86 ++++++++
 tb/tb_if_queue.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: the fetch-to-decode instruction packet and
// the default instruction-queue depth.
package lc3b_types;

  localparam int IFQ_DEPTH = 4;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } lc3b_ipacket;

endpackage

// File: rtl/if_queue_ptr.sv
// Wrapping queue pointer with increment enable and synchronous clear,
// used for both the read and write side of if_queue.
module if_queue_ptr #(
  parameter int DEPTH = 4,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [PW-1:0] o_ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] r_ptr;

  // Clear wins over increment; wrap explicitly from the last slot back to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= {PW{1'b0}};
    end else if (i_clr) begin
      r_ptr <= {PW{1'b0}};
    end else if (i_inc) begin
      if (r_ptr == LAST) begin
        r_ptr <= {PW{1'b0}};
      end else begin
        r_ptr <= r_ptr + PW'(1);
      end
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/if_queue.sv
// Instruction-fetch queue between fetch and decode: DEPTH-entry FIFO with
// flush. Optional same-cycle empty bypass is enabled by IF_QUEUE_BYPASS_EN.
import lc3b_types::*;

module if_queue #(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  lc3b_ipacket   enq_packet,
  input  logic          enq_valid,
  output logic          enq_ready,
  output lc3b_ipacket   deq_packet,
  output logic          deq_valid,
  input  logic          deq_ready,
  input  logic          flush,
  output logic [CW-1:0] count
);

  lc3b_ipacket   r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_rd_ptr;
  logic [PW-1:0] w_wr_ptr;
  logic          w_empty;
  logic          w_full;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;

  // Handshake decode: flush suppresses both sides; a bypassed packet is never stored.
  always_comb begin
    w_empty = (r_count == {CW{1'b0}});
    w_full  = (r_count == CW'(DEPTH));
`ifdef IF_QUEUE_BYPASS_EN
    w_bypass = w_empty && enq_valid && deq_ready && !flush && !rst;
`else
    w_bypass = 1'b0;
`endif
    w_push = enq_valid && !w_full && !flush && !w_bypass;
    w_pop  = !w_empty && deq_ready && !flush;
  end

  if_queue_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (flush),
    .i_inc (w_pop),
    .o_ptr (w_rd_ptr)
  );

  if_queue_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (flush),
    .i_inc (w_push),
    .o_ptr (w_wr_ptr)
  );

  // Packet storage; deliberately not cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_ptr] <= enq_packet;
    end
  end

  // Occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= {CW{1'b0}};
    end else if (flush) begin
      r_count <= {CW{1'b0}};
    end else if (w_push && !w_pop) begin
      r_count <= r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign enq_ready  = !w_full;
  assign deq_valid  = (!w_empty && !flush) || w_bypass;
  assign deq_packet = w_bypass ? enq_packet : r_mem[w_rd_ptr];
  assign count      = r_count;

endmodule

// File: tb/tb_if_queue.sv
// Directed self-checking bench for if_queue (default DEPTH=4); honours
// IF_QUEUE_BYPASS_EN for the empty-queue bypass step.
`timescale 1ns/1ps
import lc3b_types::*;

module tb_if_queue;

  logic        clk;
  logic        rst;
  lc3b_ipacket enq_packet;
  logic        enq_valid;
  logic        enq_ready;
  lc3b_ipacket deq_packet;
  logic        deq_valid;
  logic        deq_ready;
  logic        flush;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  if_queue #(.DEPTH(IFQ_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .enq_packet (enq_packet),
    .enq_valid  (enq_valid),
    .enq_ready  (enq_ready),
    .deq_packet (deq_packet),
    .deq_valid  (deq_valid),
    .deq_ready  (deq_ready),
    .flush      (flush),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic lc3b_ipacket mk(input logic [15:0] pc);
    lc3b_ipacket p;
    p.pc    = pc;
    p.instr = pc ^ 16'hA5A5;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    enq_packet = mk(16'h0000);
    enq_valid  = 1'b0;
    deq_ready  = 1'b0;
    flush      = 1'b0;

    // Reset state
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("rst_enq_ready", 32'(enq_ready), 32'd1);
    tick();
    rst = 1'b0;
    #1;

    // Fill to full with deq_ready=0
    enq_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      enq_packet = mk(16'h3000 + 16'(2 * i));
      #1;
      chk("fill_enq_ready", 32'(enq_ready), 32'd1);
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
    end
    chk("full_enq_ready", 32'(enq_ready), 32'd0);
    chk("full_deq_valid", 32'(deq_valid), 32'd1);
    chk("full_head", deq_packet, mk(16'h3000));

    // Fifth packet refused
    enq_packet = mk(16'h3008);
    tick();
    chk("refused_count", 32'(count), 32'd4);
    chk("refused_head", deq_packet, mk(16'h3000));

    // Full with deq_ready and enq_valid together: only the dequeue happens
    deq_ready = 1'b1;
    #1;
    chk("fullsim_head", deq_packet, mk(16'h3000));
    chk("fullsim_enq_ready", 32'(enq_ready), 32'd0);
    tick();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    #1;
    chk("fullsim_count", 32'(count), 32'd3);
    chk("fullsim_enq_ready_next", 32'(enq_ready), 32'd1);

    // Drain: 0x3008 must not appear
    deq_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drain_head", deq_packet, mk(16'h3002 + 16'(2 * i)));
      tick();
    end
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_deq_valid", 32'(deq_valid), 32'd0);

    // Continuous enq/deq for 10 packets, pointers wrap
    deq_ready  = 1'b0;
    enq_valid  = 1'b1;
    enq_packet = mk(16'h3000);
    tick();
    deq_ready = 1'b1;
    for (int i = 1; i < 10; i++) begin
      enq_packet = mk(16'h3000 + 16'(2 * i));
      #1;
      chk("stream_head", deq_packet, mk(16'h3000 + 16'(2 * (i - 1))));
      tick();
      chk("stream_count", 32'(count), 32'd1);
    end
    enq_valid = 1'b0;
    #1;
    chk("stream_last", deq_packet, mk(16'h3012));
    tick();
    chk("stream_end_count", 32'(count), 32'd0);

    // Flush with count=3 and an incoming packet
    deq_ready = 1'b0;
    enq_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enq_packet = mk(16'h3100 + 16'(2 * i));
      tick();
    end
    chk("preflush_count", 32'(count), 32'd3);
    flush      = 1'b1;
    deq_ready  = 1'b1;
    enq_packet = mk(16'h4000);
    #1;
    chk("flush_deq_valid", 32'(deq_valid), 32'd0);
    tick();
    flush     = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    #1;
    chk("postflush_count", 32'(count), 32'd0);
    chk("postflush_deq_valid", 32'(deq_valid), 32'd0);
    enq_valid  = 1'b1;
    enq_packet = mk(16'h4002);
    tick();
    enq_valid = 1'b0;
    #1;
    chk("postflush_one", 32'(count), 32'd1);
    chk("postflush_head", deq_packet, mk(16'h4002));
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    chk("postflush_drained", 32'(count), 32'd0);

    // Asynchronous reset mid-cycle with count=2
    enq_valid = 1'b1;
    enq_packet = mk(16'h3200);
    tick();
    enq_packet = mk(16'h3202);
    tick();
    enq_valid = 1'b0;
    chk("prereset_count", 32'(count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("async_rst_enq_ready", 32'(enq_ready), 32'd1);
    tick();
    rst = 1'b0;
    enq_valid  = 1'b1;
    enq_packet = mk(16'h3300);
    tick();
    enq_valid = 1'b0;
    #1;
    chk("afterrst_count", 32'(count), 32'd1);
    chk("afterrst_head", deq_packet, mk(16'h3300));
    deq_ready = 1'b1;
    tick();
    chk("afterrst_drained", 32'(count), 32'd0);

    // Empty queue, enq and deq together
    enq_valid  = 1'b1;
    enq_packet = mk(16'h5000);
    deq_ready  = 1'b1;
    #1;
`ifdef IF_QUEUE_BYPASS_EN
    chk("bypass_deq_valid", 32'(deq_valid), 32'd1);
    chk("bypass_pc", 32'(deq_packet.pc), 32'h5000);
    tick();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    #1;
    chk("bypass_count", 32'(count), 32'd0);
    chk("bypass_after_valid", 32'(deq_valid), 32'd0);
`else
    chk("nobypass_deq_valid", 32'(deq_valid), 32'd0);
    tick();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    #1;
    chk("nobypass_next_valid", 32'(deq_valid), 32'd1);
    chk("nobypass_next_pc", 32'(deq_packet.pc), 32'h5000);
    chk("nobypass_count", 32'(count), 32'd1);
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    chk("nobypass_drained", 32'(count), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
